decoder_3_8_fifo: RTL
=====================

DECODER_3_8_FIFO -- requirements
Module: decoder_3_8_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queued codes; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  acceptance enable; when low, no new code is accepted.
REQ-005 SHALL have port in_code  input  3  binary code to decode.
REQ-006 SHALL have port in_valid  input  1  in_code is offered this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept in_code this cycle.
REQ-008 SHALL have port out_onehot  output  8  one-hot decode of the head entry.
REQ-009 SHALL have port out_valid  output  1  out_onehot holds a queued entry.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_onehot this cycle.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current number of queued entries.

Function
REQ-012 SHALL accept a code on a clock edge where in_valid && in_ready, with in_ready = en && (level < DEPTH).
REQ-013 SHALL pop the head entry on a clock edge where out_valid && out_ready, with out_valid = (level != 0).
REQ-014 SHALL drive out_onehot = 8'b1 << head_code when out_valid, and 8'h00 when level == 0.
REQ-015 SHALL give one-cycle latency: a code accepted at edge N appears on out_onehot after edge N when the queue was empty.
REQ-016 SHALL preserve strict FIFO order; read/write pointers wrap modulo DEPTH with no gap or duplication.
REQ-017 SHALL, on a simultaneous accept and pop, keep level unchanged; this is legal at any level between 1 and DEPTH-1.
REQ-018 SHALL, when full (level == DEPTH), deassert in_ready with no same-cycle pass-through, even if out_ready is high.
REQ-019 SHALL ignore out_ready when empty; level never underflows, and out_onehot stays 8'h00.
REQ-020 SHALL keep draining queued entries while en is low; en affects acceptance only.
REQ-021 SHALL hold out_onehot and out_valid stable while out_valid && !out_ready.

Reset
REQ-022 SHALL, on rst high, asynchronously clear both pointers and level to 0, drive out_valid=0, out_onehot=8'h00, and in_ready=0 while rst is high.
REQ-023 SHALL discard all queued entries when reset asserts mid-operation; the first edge after release behaves as an empty queue.
REQ-024 SHALL clear err (see REQ-026) on reset.

Configuration
REQ-025 SHALL support macro DEC38_PARITY_EN.
REQ-026 SHALL, with DEC38_PARITY_EN defined:
- add port in_par  input  1, carrying odd parity over in_code, so that ^{in_code,in_par} must be 1.
- add port err  output  1, a sticky parity-error flag.
- on a handshake with wrong parity, not queue the code, leave level unchanged, and set err until reset.
- leave in_ready unaffected by parity.
REQ-027 SHALL, without DEC38_PARITY_EN, have no in_par or err ports and queue every accepted code.

Verification
REQ-028 SHALL cover: after reset, push in_code=3'd5 with out_ready=0 -> next cycle out_valid=1, out_onehot=8'h20, level=1.
REQ-029 SHALL cover: DEPTH=4, push codes 0,1,2,3 with out_ready=0 -> in_ready=0, level=4; a fifth offer of code 7 is not accepted; then drain -> 8'h01, 8'h02, 8'h04, 8'h08 in order.
REQ-030 SHALL cover: level=2 with in_valid=1 and out_ready=1 for 6 cycles on codes 4..7,0,1 -> level stays 2 and pointers wrap with order intact.
REQ-031 SHALL cover: en=0 with in_valid=1 and level=3 -> no accepts, three pops deliver the queued entries, then out_onehot=8'h00.
REQ-032 SHALL cover: rst pulsed mid-cycle with level=3 -> level=0, out_valid=0, out_onehot=8'h00 immediately, without waiting for a clock edge.
REQ-033 SHALL cover, with DEC38_PARITY_EN: push in_code=3'd3 with in_par=0 -> err=1, level unchanged; push in_code=3'd3 with in_par=1 -> out_onehot=8'h08.

Source files
------------

// File: rtl/decoder_3_8_fifo.sv
// Queued 3-to-8 decoder: codes enter a small FIFO, the head drives a one-hot output.
// Optional odd-parity check on in_code is enabled by defining DEC38_PARITY_EN.
module decoder_3_8_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               in_code,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_onehot,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef DEC38_PARITY_EN
  input  logic                     in_par,
  output logic                     err,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

  assign full      = (level == FULL_LVL);
  // rst gates in_ready so nothing appears acceptable while held in reset
  assign in_ready  = en && !full && !rst;
  assign out_valid = (level != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef DEC38_PARITY_EN
  logic par_ok;
  assign par_ok = ^{in_code, in_par};
  assign push   = accept && par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (accept && !par_ok)
      err <= 1'b1;
  end
`else
  assign push = accept;
`endif

  always_comb begin
    out_onehot = 8'h00;
    if (out_valid)
      out_onehot = 8'h01 << mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
